// File: rtl/aes_round_sequencer.sv
`timescale 1ns/1ps
// aes_round_sequencer: control FSM that walks one AES-128/192/256 encryption
// through AddRoundKey / SubBytes / ShiftRows / MixColumns over the shared
// statemt buffer. Control only: it raises one leaf start at a time, selects
// the buffer owner, and tracks the round index fed to AddRoundKey.
module aes_round_sequencer #(
    parameter int NR_W = 4
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    input  logic            ap_start,
    input  logic [1:0]      key_len,
    output logic            ap_done,
    output logic            ap_ready,
    output logic            ap_idle,
    output logic            ark_start,
    input  logic            ark_done,
    output logic [NR_W-1:0] ark_n,
    output logic            sub_start,
    input  logic            sub_done,
    output logic            shr_start,
    input  logic            shr_done,
    output logic            mix_start,
    input  logic            mix_done,
    output logic [1:0]      mem_sel,
    output logic [NR_W-1:0] round
);

    // Bit positions of the one-hot state register.
    localparam int S_IDLE = 0;
    localparam int S_ARK  = 1;
    localparam int S_SUB  = 2;
    localparam int S_SHR  = 3;
    localparam int S_MIX  = 4;
    localparam int S_FIN  = 5;

    localparam logic [5:0] ST_IDLE = 6'b000001;
    localparam logic [5:0] ST_ARK  = 6'b000010;
    localparam logic [5:0] ST_SUB  = 6'b000100;
    localparam logic [5:0] ST_SHR  = 6'b001000;
    localparam logic [5:0] ST_MIX  = 6'b010000;
    localparam logic [5:0] ST_FIN  = 6'b100000;

    logic [5:0]      state_q, state_d;
    logic [NR_W-1:0] round_q, round_d;
    logic [NR_W-1:0] nr_q, nr_d;

    // Round count for the selected key length; the reserved code falls back to AES-128.
    function automatic logic [NR_W-1:0] nr_from_key(input logic [1:0] kl);
        case (kl)
            2'd1:    return NR_W'(12);
            2'd2:    return NR_W'(14);
            default: return NR_W'(10);
        endcase
    endfunction

    // State, round and latched Nr registers with synchronous active-low reset.
    always_ff @(posedge ap_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            nr_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
        end
    end

    // Next-state logic: a leaf done only counts in the state that started that leaf.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        case (1'b1)
            state_q[S_IDLE]: begin
                if (ap_start) begin
                    nr_d    = nr_from_key(key_len);
                    round_d = '0;
                    state_d = ST_ARK;
                end
            end
            state_q[S_ARK]: begin
                if (ark_done) begin
                    if (round_q == nr_q) begin
                        state_d = ST_FIN;
                    end else begin
                        round_d = round_q + NR_W'(1);
                        state_d = ST_SUB;
                    end
                end
            end
            state_q[S_SUB]: begin
                if (sub_done) state_d = ST_SHR;
            end
            state_q[S_SHR]: begin
                // The final round skips MixColumns.
                if (shr_done) state_d = (round_q == nr_q) ? ST_ARK : ST_MIX;
            end
            state_q[S_MIX]: begin
                if (mix_done) state_d = ST_ARK;
            end
            state_q[S_FIN]: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from state only: one start level per phase plus buffer owner.
    always_comb begin
        ark_start = 1'b0;
        sub_start = 1'b0;
        shr_start = 1'b0;
        mix_start = 1'b0;
        ap_done   = 1'b0;
        mem_sel   = 2'd0;
        case (1'b1)
            state_q[S_ARK]: begin
                ark_start = 1'b1;
                mem_sel   = 2'd0;
            end
            state_q[S_SUB]: begin
                sub_start = 1'b1;
                mem_sel   = 2'd1;
            end
            state_q[S_SHR]: begin
                shr_start = 1'b1;
                mem_sel   = 2'd2;
            end
            state_q[S_MIX]: begin
                mix_start = 1'b1;
                mem_sel   = 2'd3;
            end
            state_q[S_FIN]: begin
                ap_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ap_ready = ap_done;
    assign ap_idle  = state_q[S_IDLE] & ~ap_start;
    assign ark_n    = round_q;
    assign round    = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for aes_round_sequencer. Leaves are modelled as fixed
// latency responders with optional stray dones while idle; each encryption is
// checked against an invocation list and a latency built from the AES round
// structure.
module tb_aes_round_sequencer;

    localparam int NR_W = 4;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic            ap_start;
    logic [1:0]      key_len;
    logic            ap_done, ap_ready, ap_idle;
    logic            ark_start, sub_start, shr_start, mix_start;
    logic            ark_done, sub_done, shr_done, mix_done;
    logic [NR_W-1:0] ark_n, round;
    logic [1:0]      mem_sel;

    aes_round_sequencer #(.NR_W(NR_W)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ap_start  (ap_start),
        .key_len   (key_len),
        .ap_done   (ap_done),
        .ap_ready  (ap_ready),
        .ap_idle   (ap_idle),
        .ark_start (ark_start),
        .ark_done  (ark_done),
        .ark_n     (ark_n),
        .sub_start (sub_start),
        .sub_done  (sub_done),
        .shr_start (shr_start),
        .shr_done  (shr_done),
        .mix_start (mix_start),
        .mix_done  (mix_done),
        .mem_sel   (mem_sel),
        .round     (round)
    );

    always #5 ap_clk = ~ap_clk;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- leaf models ----------------
    // Index 0..3 = ARK, SUB, SHR, MIX (same order as the mem_sel codes).
    logic [3:0] st, dn, stray_bits, stray_now;
    int         dly [4];
    int         cnt [4];
    int         stray_mode;  // 0 none, 1 random, 2 all idle dones held high

    assign st = {mix_start, shr_start, sub_start, ark_start};
    assign stray_now = (stray_mode == 2) ? 4'hF : (stray_mode == 1) ? stray_bits : 4'h0;

    always_comb begin
        dn = '0;
        for (int i = 0; i < 4; i++)
            dn[i] = st[i] ? (cnt[i] == dly[i]) : stray_now[i];
    end

    assign ark_done = dn[0];
    assign sub_done = dn[1];
    assign shr_done = dn[2];
    assign mix_done = dn[3];

    initial begin
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        stray_bits = '0;
    end

    always @(posedge ap_clk) begin
        for (int i = 0; i < 4; i++)
            if (st[i] && !dn[i]) cnt[i] <= cnt[i] + 1;
            else                 cnt[i] <= 0;
    end

    always @(posedge ap_clk) begin
        #1 stray_bits = 4'($urandom);
    end

    // ---------------- monitor ----------------
    typedef struct {
        int leaf;
        int n;
    } inv_t;

    inv_t inv_q [$];
    int   done_cnt = 0;
    bit   mon_en = 1'b0;
    logic [3:0] st_prev = '0;
    logic [3:0] dn_prev = '0;
    logic [NR_W-1:0] n_prev = '0;

    always @(negedge ap_clk) begin
        int idx;
        if (mon_en) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (st[i]) idx = i;
            if (st != 4'h0 && st != st_prev) begin
                inv_t e;
                e.leaf = idx;
                e.n    = (idx == 0) ? int'(ark_n) : 0;
                inv_q.push_back(e);
            end
            check("start_onehot", 32'($countones(st) <= 1), 32'd1);
            check("ready_eq_done", 32'(ap_ready), 32'(ap_done));
            if (st != 4'h0) begin
                check("mem_sel", 32'(mem_sel), 32'(idx));
                check("idle_in_run", 32'(ap_idle), 32'd0);
            end
            if (ap_done) begin
                check("start_in_fin", 32'(st), 32'd0);
                done_cnt++;
            end
            for (int i = 0; i < 4; i++) begin
                if (st_prev[i] && dn_prev[i])
                    check("start_drop", 32'(st[i]), 32'd0);
                else if (st_prev[i])
                    check("start_hold", 32'(st[i]), 32'd1);
            end
            if (st_prev[0] && st[0])
                check("ark_n_stable", 32'(ark_n), 32'(n_prev));
        end
        st_prev = st;
        dn_prev = dn;
        n_prev  = ark_n;
    end

    // ---------------- reference model ----------------
    function automatic int nr_of(input logic [1:0] kl);
        return (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
    endfunction

    // One encryption: initial ARK, Nr-1 full rounds, one final round without MIX.
    task automatic build_expect(input int nr, output inv_t q [$]);
        inv_t e;
        q.delete();
        e.leaf = 0; e.n = 0; q.push_back(e);
        for (int r = 1; r <= nr; r++) begin
            e.leaf = 1; e.n = 0; q.push_back(e);
            e.leaf = 2; e.n = 0; q.push_back(e);
            if (r < nr) begin e.leaf = 3; e.n = 0; q.push_back(e); end
            e.leaf = 0; e.n = r; q.push_back(e);
        end
    endtask

    task automatic set_dly(input bit zero);
        for (int i = 0; i < 4; i++) dly[i] = zero ? 0 : int'($urandom_range(0, 3));
    endtask

    // Full encryption from IDLE with ap_start dropped right after accept.
    task automatic run_one(input logic [1:0] kl, input string tag);
        inv_t exp_q [$];
        int   lat, exp_lat, w, nexp;
        build_expect(nr_of(kl), exp_q);
        exp_lat = 1;
        foreach (exp_q[k]) exp_lat += dly[exp_q[k].leaf] + 1;
        @(negedge ap_clk);
        mon_en   = 1'b1;
        inv_q.delete();
        done_cnt = 0;
        check({tag, ":idle_before"}, 32'(ap_idle), 32'd1);
        ap_start = 1'b1;
        key_len  = kl;
        @(negedge ap_clk);
        check({tag, ":accept"}, 32'(ark_start), 32'd1);
        check({tag, ":ark_n0"}, 32'(ark_n), 32'd0);
        ap_start = 1'b0;
        key_len  = 2'($urandom);
        lat = 1;
        w   = 0;
        while (!ap_done && w < 4000) begin
            @(negedge ap_clk);
            lat++;
            w++;
        end
        if (!ap_done) begin
            check({tag, ":done_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        @(negedge ap_clk);
        check({tag, ":done_pulse"}, 32'(ap_done), 32'd0);
        check({tag, ":idle_after"}, 32'(ap_idle), 32'd1);
        check({tag, ":done_count"}, 32'(done_cnt), 32'd1);
        check({tag, ":inv_count"}, 32'(inv_q.size()), 32'(exp_q.size()));
        nexp = (inv_q.size() < exp_q.size()) ? inv_q.size() : exp_q.size();
        for (int k = 0; k < nexp; k++)
            check({tag, ":inv_seq"}, 32'(inv_q[k].leaf * 256 + inv_q[k].n),
                  32'(exp_q[k].leaf * 256 + exp_q[k].n));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        ap_rst_n   = 1'b0;
        ap_start   = 1'b1;
        key_len    = 2'd0;
        stray_mode = 0;
        set_dly(1'b1);

        // Reset state, with ap_start high then low to see ap_idle follow it.
        repeat (3) @(negedge ap_clk);
        check("rst:starts", 32'(st), 32'd0);
        check("rst:done", 32'(ap_done), 32'd0);
        check("rst:ready", 32'(ap_ready), 32'd0);
        check("rst:mem_sel", 32'(mem_sel), 32'd0);
        check("rst:round", 32'(round), 32'd0);
        check("rst:idle_start1", 32'(ap_idle), 32'd0);
        ap_start = 1'b0;
        #1;
        check("rst:idle_start0", 32'(ap_idle), 32'd1);
        ap_rst_n = 1'b1;

        // AES-128 with three-cycle leaves.
        for (int i = 0; i < 4; i++) dly[i] = 3;
        run_one(2'd0, "nr10");

        // AES-256 with random latencies and random stray dones.
        set_dly(1'b0);
        stray_mode = 1;
        run_one(2'd2, "nr14");

        // Reserved key length with every idle leaf's done held high.
        set_dly(1'b0);
        stray_mode = 2;
        run_one(2'd3, "kl3");

        // AES-192.
        set_dly(1'b0);
        stray_mode = 1;
        run_one(2'd1, "nr12");

        // Zero-wait leaves: one cycle per phase.
        set_dly(1'b1);
        stray_mode = 2;
        run_one(2'd0, "zero_wait");

        // Random mix.
        for (int r = 0; r < 4; r++) begin
            set_dly(1'b0);
            stray_mode = int'($urandom_range(0, 2));
            run_one(2'($urandom), "rand");
        end

        // Reset during the round-5 MixColumns phase, then a clean run.
        set_dly(1'b0);
        stray_mode = 1;
        @(negedge ap_clk);
        ap_start = 1'b1;
        key_len  = 2'd0;
        @(negedge ap_clk);
        ap_start = 1'b0;
        w = 0;
        while (!(mix_start && round == NR_W'(5)) && w < 4000) begin
            @(negedge ap_clk);
            w++;
        end
        if (!(mix_start && round == NR_W'(5))) begin
            check("midrst:reach_mix5_timeout", 32'd0, 32'd1);
        end else begin
            mon_en   = 1'b0;
            ap_rst_n = 1'b0;
            @(negedge ap_clk);
            ap_rst_n = 1'b1;
            check("midrst:starts", 32'(st), 32'd0);
            check("midrst:round", 32'(round), 32'd0);
            check("midrst:idle", 32'(ap_idle), 32'd1);
            check("midrst:done", 32'(ap_done), 32'd0);
            check("midrst:mem_sel", 32'(mem_sel), 32'd0);
        end
        run_one(2'd0, "after_rst");

        // Back-to-back: ap_start held high across two encryptions.
        set_dly(1'b0);
        stray_mode = 1;
        @(negedge ap_clk);
        inv_q.delete();
        done_cnt = 0;
        ap_start = 1'b1;
        key_len  = 2'd0;
        for (int k = 0; k < 2; k++) begin
            w = 0;
            while (!ap_done && w < 4000) begin
                @(negedge ap_clk);
                w++;
            end
            check("b2b:done_seen", 32'(ap_done), 32'd1);
            if (k == 0) begin
                @(negedge ap_clk);
                check("b2b:gap_no_start", 32'(st), 32'd0);
                check("b2b:gap_idle_low", 32'(ap_idle), 32'd0);
                @(negedge ap_clk);
                check("b2b:restart", 32'(ark_start), 32'd1);
                check("b2b:restart_n", 32'(ark_n), 32'd0);
            end
        end
        ap_start = 1'b0;
        @(negedge ap_clk);
        check("b2b:done_pulse", 32'(ap_done), 32'd0);
        check("b2b:idle_end", 32'(ap_idle), 32'd1);
        check("b2b:done_count", 32'(done_cnt), 32'd2);
        check("b2b:inv_count", 32'(inv_q.size()), 32'd80);

        repeat (2) @(negedge ap_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute bound on simulation time.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
